// File: rtl/sprite_draw_scheduler.sv
// Sequences erase/redraw of NUM_SPR 4x4 sprite tiles onto a single pixel plot port
// once per frame_tick, snapshotting sprite inputs at the start of each pass.
module sprite_draw_scheduler #(
  parameter int         NUM_SPR   = 4,
  parameter logic [2:0] BG_COLOUR = 3'b111
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [NUM_SPR-1:0]     spr_en,
  input  logic [8*NUM_SPR-1:0]   spr_x,
  input  logic [7*NUM_SPR-1:0]   spr_y,
  input  logic [3*NUM_SPR-1:0]   spr_c,
  input  logic [3*NUM_SPR-1:0]   spr_c2,
  input  logic [NUM_SPR-1:0]     spr_alt,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             c_out,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPR - 1);

  typedef enum logic [2:0] {
    IDLE, SNAP, SELECT, ERASE, DRAW, NEXT, DONE
  } state_e;

  state_e                      state_q;
  logic [IW-1:0]               idx_q;
  logic [3:0]                  offset_q;
  logic [NUM_SPR-1:0]          drawn_q;
  logic [NUM_SPR-1:0]          en_q;
  logic [NUM_SPR-1:0]          alt_q;
  logic [NUM_SPR-1:0][7:0]     shx_q;
  logic [NUM_SPR-1:0][6:0]     shy_q;
  logic [NUM_SPR-1:0][2:0]     shc_q;
  logic [NUM_SPR-1:0][2:0]     shc2_q;
  logic [NUM_SPR-1:0][7:0]     oldx_q;
  logic [NUM_SPR-1:0][6:0]     oldy_q;
  logic                        overrun_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      offset_q  <= '0;
      drawn_q   <= '0;
      en_q      <= '0;
      alt_q     <= '0;
      shx_q     <= '0;
      shy_q     <= '0;
      shc_q     <= '0;
      shc2_q    <= '0;
      oldx_q    <= '0;
      oldy_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= frame_tick && (state_q != IDLE);
      case (state_q)
        IDLE: if (frame_tick) state_q <= SNAP;
        SNAP: begin
          en_q    <= spr_en;
          alt_q   <= spr_alt;
          shx_q   <= spr_x;
          shy_q   <= spr_y;
          shc_q   <= spr_c;
          shc2_q  <= spr_c2;
          idx_q   <= '0;
          state_q <= SELECT;
        end
        SELECT: begin
          offset_q <= '0;
          if (drawn_q[idx_q])   state_q <= ERASE;
          else if (en_q[idx_q]) state_q <= DRAW;
          else                  state_q <= NEXT;
        end
        ERASE: begin
          offset_q <= offset_q + 4'd1;
          if (offset_q == 4'd15) begin
            if (en_q[idx_q]) begin
              state_q <= DRAW;
            end else begin
              drawn_q[idx_q] <= 1'b0;
              state_q        <= NEXT;
            end
          end
        end
        DRAW: begin
          offset_q <= offset_q + 4'd1;
          if (offset_q == 4'd15) begin
            oldx_q[idx_q]  <= shx_q[idx_q];
            oldy_q[idx_q]  <= shy_q[idx_q];
            drawn_q[idx_q] <= 1'b1;
            state_q        <= NEXT;
          end
        end
        NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= SELECT;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Plot port is a pure decode of registered state, so reset clears it asynchronously
  always_comb begin
    writeEn = 1'b0;
    x_out   = '0;
    y_out   = '0;
    c_out   = '0;
    if (state_q == ERASE) begin
      writeEn = 1'b1;
      x_out   = oldx_q[idx_q] + {6'b0, offset_q[1:0]};
      y_out   = oldy_q[idx_q] + {5'b0, offset_q[3:2]};
      c_out   = BG_COLOUR;
    end else if (state_q == DRAW) begin
      writeEn = 1'b1;
      x_out   = shx_q[idx_q] + {6'b0, offset_q[1:0]};
      y_out   = shy_q[idx_q] + {5'b0, offset_q[3:2]};
      c_out   = (alt_q[idx_q] && offset_q[0]) ? shc2_q[idx_q] : shc_q[idx_q];
    end
  end

  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Scoreboard bench for sprite_draw_scheduler: expected plot writes are queued by the
// stimulus and popped by an independent monitor on every writeEn cycle.
module tb_sprite_draw_scheduler;

  localparam int NUM_SPR = 4;
  localparam logic [2:0] BG = 3'b111;

  logic                 clk;
  logic                 resetn;
  logic                 frame_tick;
  logic [NUM_SPR-1:0]   spr_en;
  logic [8*NUM_SPR-1:0] spr_x;
  logic [7*NUM_SPR-1:0] spr_y;
  logic [3*NUM_SPR-1:0] spr_c;
  logic [3*NUM_SPR-1:0] spr_c2;
  logic [NUM_SPR-1:0]   spr_alt;
  logic [7:0]           x_out;
  logic [6:0]           y_out;
  logic [2:0]           c_out;
  logic                 writeEn;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;

  int checks = 0;
  int failures = 0;
  logic [17:0] expQ [$];

  sprite_draw_scheduler #(.NUM_SPR(NUM_SPR), .BG_COLOUR(BG)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_c(spr_c),
    .spr_c2(spr_c2), .spr_alt(spr_alt),
    .x_out(x_out), .y_out(y_out), .c_out(c_out), .writeEn(writeEn),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic setSprite(input int i, input logic en, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic [2:0] c2, input logic alt);
    spr_en[i]       = en;
    spr_x[8*i +: 8] = x;
    spr_y[7*i +: 7] = y;
    spr_c[3*i +: 3] = c;
    spr_c2[3*i +: 3] = c2;
    spr_alt[i]      = alt;
  endtask

  // Expected {x,y,colour} for one tile, raster order with x fastest
  task automatic pushTile(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                          input logic [2:0] c2, input logic alt, input int count);
    for (int o = 0; o < count; o++) begin
      logic [3:0] ob;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
      ob = o[3:0];
      px = x + {6'b0, ob[1:0]};
      py = y + {5'b0, ob[3:2]};
      pc = (alt && ob[0]) ? c2 : c;
      expQ.push_back({px, py, pc});
    end
  endtask

  // Monitor: compares each plotted pixel against the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && writeEn) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write", {14'b0, x_out, y_out, c_out}, 32'hFFFF_FFFF);
        end else begin
          logic [17:0] e;
          e = expQ.pop_front();
          checkOutput("pixel", {14'b0, x_out, y_out, c_out}, {14'b0, e});
        end
      end else if (resetn && busy) begin
        checkOutput("idle_plot_zero", {14'b0, x_out, y_out, c_out}, 32'h0);
      end
    end
  end

  // Issue one tick and follow the pass; optional extra tick or reset at cycle n (SNAP is n=1)
  task automatic applyStimulus(input int tickAt, input int resetAt,
                               output int doneN, output int firstW, output int writes, output int ovr);
    int n;
    doneN = 0; firstW = 0; writes = 0; ovr = 0; n = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (writeEn) begin
        writes++;
        if (firstW == 0) firstW = n;
      end
      if (overrun) ovr++;
      frame_tick = (n == tickAt);
      if (n == resetAt) begin
        resetn = 1'b0;
        #1;
        checkOutput("reset_writeEn", {31'b0, writeEn}, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        #1 resetn = 1'b1;
        frame_tick = 1'b0;
        return;
      end
      if (frame_done) begin
        doneN = n;
        break;
      end
    end
    if (doneN == 0) checkOutput("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (overrun) ovr++;
    frame_tick = 1'b0;
    checkOutput("idle_after_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic runPass(input string name, input int tickAt, input int expDone,
                         input int expWrites, input int expOvr);
    int d, f, w, o;
    applyStimulus(tickAt, 0, d, f, w, o);
    checkOutput({name, "_done_cycle"}, d, expDone);
    checkOutput({name, "_writes"}, w, expWrites);
    checkOutput({name, "_overrun"}, o, expOvr);
    checkOutput({name, "_queue_empty"}, expQ.size(), 0);
    if (expWrites > 0) checkOutput({name, "_first_write"}, f, 3);
  endtask

  initial begin
    int d, f, w, o;
    resetn = 1'b0; frame_tick = 1'b0;
    spr_en = '0; spr_x = '0; spr_y = '0; spr_c = '0; spr_c2 = '0; spr_alt = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_writeEn", {31'b0, writeEn}, 0);
    checkOutput("rst_done_ovr", {30'b0, frame_done, overrun}, 0);
    checkOutput("rst_plot", {14'b0, x_out, y_out, c_out}, 0);
    resetn = 1'b1;

    // 1: single sprite first draw
    setSprite(0, 1'b1, 8'd10, 7'd20, 3'b100, 3'b000, 1'b0);
    pushTile(8'd10, 7'd20, 3'b100, 3'b000, 1'b0, 16);
    runPass("t1", 0, 26, 16, 0);

    // 2: move -> erase old then draw new
    setSprite(0, 1'b1, 8'd11, 7'd20, 3'b100, 3'b000, 1'b0);
    pushTile(8'd10, 7'd20, BG, BG, 1'b0, 16);
    pushTile(8'd11, 7'd20, 3'b100, 3'b000, 1'b0, 16);
    runPass("t2", 0, 42, 32, 0);

    // 3: striped sprite 1; sprite 0 erase confirms old_x became 11
    setSprite(1, 1'b1, 8'd0, 7'd0, 3'b001, 3'b010, 1'b1);
    pushTile(8'd11, 7'd20, BG, BG, 1'b0, 16);
    pushTile(8'd11, 7'd20, 3'b100, 3'b000, 1'b0, 16);
    expQ.push_back({8'd0, 7'd0, 3'd1}); expQ.push_back({8'd1, 7'd0, 3'd2});
    expQ.push_back({8'd2, 7'd0, 3'd1}); expQ.push_back({8'd3, 7'd0, 3'd2});
    pushTile(8'd0, 7'd1, 3'b001, 3'b010, 1'b1, 12);
    runPass("t3", 0, 58, 48, 0);

    // 4: wrap at (254,126)
    setSprite(2, 1'b1, 8'd254, 7'd126, 3'b011, 3'b000, 1'b0);
    pushTile(8'd11, 7'd20, BG, BG, 1'b0, 16);
    pushTile(8'd11, 7'd20, 3'b100, 3'b000, 1'b0, 16);
    pushTile(8'd0, 7'd0, BG, BG, 1'b0, 16);
    pushTile(8'd0, 7'd0, 3'b001, 3'b010, 1'b1, 16);
    expQ.push_back({8'd254, 7'd126, 3'd3}); expQ.push_back({8'd255, 7'd126, 3'd3});
    expQ.push_back({8'd0, 7'd126, 3'd3});   expQ.push_back({8'd1, 7'd126, 3'd3});
    expQ.push_back({8'd254, 7'd127, 3'd3}); expQ.push_back({8'd255, 7'd127, 3'd3});
    expQ.push_back({8'd0, 7'd127, 3'd3});   expQ.push_back({8'd1, 7'd127, 3'd3});
    pushTile(8'd254, 7'd0, 3'b011, 3'b000, 1'b0, 8);
    runPass("t4", 0, 90, 80, 0);

    // 5: disable all drawn sprites -> erase only, then nothing
    spr_en = '0;
    pushTile(8'd11, 7'd20, BG, BG, 1'b0, 16);
    pushTile(8'd0, 7'd0, BG, BG, 1'b0, 16);
    pushTile(8'd254, 7'd126, BG, BG, 1'b0, 16);
    runPass("t5a", 0, 58, 48, 0);
    runPass("t5b", 0, 10, 0, 0);

    // 6: ticks while busy and in DONE are dropped and flagged
    setSprite(0, 1'b1, 8'd5, 7'd5, 3'b010, 3'b000, 1'b0);
    pushTile(8'd5, 7'd5, 3'b010, 3'b000, 1'b0, 16);
    runPass("t6a", 10, 26, 16, 1);
    pushTile(8'd5, 7'd5, BG, BG, 1'b0, 16);
    pushTile(8'd5, 7'd5, 3'b010, 3'b000, 1'b0, 16);
    runPass("t6b", 42, 42, 32, 1);

    // Reset during DRAW offset 3, then a fresh pass draws without erasing
    pushTile(8'd5, 7'd5, BG, BG, 1'b0, 16);
    pushTile(8'd5, 7'd5, 3'b010, 3'b000, 1'b0, 4);
    applyStimulus(0, 22, d, f, w, o);
    checkOutput("t6c_writes_before_reset", w, 20);
    checkOutput("t6c_queue_empty", expQ.size(), 0);
    pushTile(8'd5, 7'd5, 3'b010, 3'b000, 1'b0, 16);
    runPass("t6d", 0, 26, 16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
